// File: rtl/led_cmd_sequencer.sv
// led_cmd_sequencer: buffers {lit, code} LED commands in a small FIFO and
// replays them to the LED interpreter, holding each one on LEDCode/Lit for
// HOLD_CYCLES cycles so that visible sequences are paced.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing being held; pops the head as soon as the FIFO has data
//   HOLD  | a command is presented; cnt counts down the remaining cycles
//
// flush has priority over everything except reset. It empties the FIFO and
// returns the outputs to 8'h00/0, which the interpreter treats as clear-all.
module led_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_code,
  input  logic                     cmd_lit,
  output logic                     cmd_ready,
  input  logic                     flush,
  output logic [7:0]               LEDCode,
  output logic                     Lit,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [8:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic               full, empty;
  logic               push, pop;

  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  assign cmd_ready = !full;
  assign level     = level_q;
  assign busy      = (state_q == HOLD) || !empty;

  // A push is blocked when full (even if a pop happens on the same edge)
  // and discarded when it coincides with a flush.
  assign push = cmd_valid && !full && !flush;

  // Next-state logic: decides when the head is popped and how the hold
  // counter moves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!empty) begin
          pop   = 1'b1;
          cnt_d = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      pop     = 1'b0;
    end
  end

  // State and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_lit, cmd_code};
    end
  end

  // FIFO pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Registered command outputs; they keep the last command when nothing pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LEDCode <= 8'h00;
      Lit     <= 1'b0;
    end else if (flush) begin
      LEDCode <= 8'h00;
      Lit     <= 1'b0;
    end else if (pop) begin
      {Lit, LEDCode} <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Testbench for led_cmd_sequencer (DEPTH=4, HOLD_CYCLES=4). Every accepted
// command is queued as the expected next output; the monitor pops and
// compares whenever {Lit, LEDCode} changes. All directed commands differ
// from their predecessor and are never 9'h000, so a change always marks a
// new presentation; the clear caused by reset/flush is flagged via skip_clear.
module tb_led_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code = 8'h00;
  logic       cmd_lit = 1'b0;
  logic       flush = 1'b0;
  logic       cmd_ready;
  logic [7:0] LEDCode;
  logic       Lit;
  logic       busy;
  logic [2:0] level;

  int total = 0;
  int bad = 0;
  logic [8:0] sb_q[$];
  bit skip_clear = 1'b0;
  logic [8:0] mon_prev = 9'h000;

  led_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_lit   (cmd_lit),
    .cmd_ready (cmd_ready),
    .flush     (flush),
    .LEDCode   (LEDCode),
    .Lit       (Lit),
    .busy      (busy),
    .level     (level)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Monitor: each new presented command must be the oldest expected one.
  always @(negedge clk) begin : monitor
    logic [8:0] cur;
    logic [8:0] exp_w;
    cur = {Lit, LEDCode};
    if (cur !== mon_prev) begin
      if (skip_clear && cur == 9'h000) begin
        skip_clear = 1'b0;
      end else if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %h, none expected", cur);
      end else begin
        exp_w = sb_q.pop_front();
        total++;
        if (cur !== exp_w) begin
          bad++;
          $display("FAIL sb_order: got %h expected %h", cur, exp_w);
        end
      end
      mon_prev = cur;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command, holding it while cmd_ready is low.
  task automatic push_word(input logic [8:0] w, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    cmd_valid = 1'b1;
    cmd_lit = w[8];
    cmd_code = w[7:0];
    for (int i = 0; i < 64 && !acc; i++) begin
      if (cmd_ready) begin
        acc = 1'b1;
        sb_q.push_back(w);
      end else begin
        stalls++;
      end
      step();
    end
    cmd_valid = 1'b0;
    check("push_accept", acc, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    check("idle_timeout", busy, 0);
  endtask

  logic [8:0] burst_w [4];
  logic [8:0] trace   [17];
  logic [2:0] lvl_tr  [17];
  logic [8:0] exp_tr;
  logic [8:0] full_w  [8];
  int st;
  int max_lvl;

  initial begin
    // Reset state
    #2;
    check("rst_code", LEDCode, 8'h00);
    check("rst_lit", Lit, 0);
    check("rst_level", level, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: async reset mid-HOLD with level 2
    push_word(9'h1A5, st);
    push_word(9'h0B6, st);
    push_word(9'h1C7, st);
    check("t1_level", level, 2);
    check("t1_busy", busy, 1);
    check("t1_code", LEDCode, 8'hA5);
    skip_clear = 1'b1;
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    check("t1_rst_code", LEDCode, 8'h00);
    check("t1_rst_lit", Lit, 0);
    check("t1_rst_level", level, 0);
    check("t1_rst_ready", cmd_ready, 1);
    check("t1_rst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    step();
    step();

    // 2: single command {1, 8'h03}
    push_word(9'h103, st);
    check("t2_no_bypass", LEDCode, 8'h00);
    check("t2_level", level, 1);
    step();
    check("t2_code", LEDCode, 8'h03);
    check("t2_lit", Lit, 1);
    check("t2_busy_n1", busy, 1);
    step();
    step();
    check("t2_busy_n3", busy, 1);
    check("t2_code_n3", LEDCode, 8'h03);
    step();
    step();
    check("t2_busy_n5", busy, 0);
    check("t2_hold_code", LEDCode, 8'h03);
    check("t2_hold_lit", Lit, 1);

    // 3: burst of four; each visible exactly HOLD cycles, no gap
    burst_w[0] = 9'h001;
    burst_w[1] = 9'h102;
    burst_w[2] = 9'h003;
    burst_w[3] = 9'h104;
    for (int k = 0; k < 17; k++) begin
      if (k < 4) begin
        cmd_valid = 1'b1;
        cmd_lit = burst_w[k][8];
        cmd_code = burst_w[k][7:0];
        if (cmd_ready) sb_q.push_back(burst_w[k]);
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      trace[k] = {Lit, LEDCode};
      lvl_tr[k] = level;
    end
    max_lvl = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 0) exp_tr = 9'h103;
      else exp_tr = burst_w[(k - 1) / HOLD];
      check($sformatf("t3_trace%0d", k), trace[k], exp_tr);
      if (int'(lvl_tr[k]) > max_lvl) max_lvl = int'(lvl_tr[k]);
    end
    check("t3_level_e4", lvl_tr[3], 3);
    check("t3_level_peak", max_lvl, 3);
    wait_idle();

    // 4: fill to full, stall the producer, wrap the pointers
    full_w[0] = 9'h1A1; full_w[1] = 9'h0B2; full_w[2] = 9'h1C3; full_w[3] = 9'h0D4;
    full_w[4] = 9'h1E5; full_w[5] = 9'h0F6; full_w[6] = 9'h107; full_w[7] = 9'h0F8;
    for (int i = 0; i < 5; i++) push_word(full_w[i], st);
    check("t4_stall_w5", st, 0);
    check("t4_full_ready", cmd_ready, 0);
    check("t4_full_level", level, 4);
    push_word(full_w[5], st);
    check("t4_stall_w6", st, 1);
    check("t4_level_w6", level, 4);
    push_word(full_w[6], st);
    push_word(full_w[7], st);
    wait_idle();
    check("t4_last_code", LEDCode, 8'hF8);

    // 5: flush during HOLD with level 3 and a concurrent push
    push_word(9'h121, st);
    push_word(9'h022, st);
    push_word(9'h123, st);
    push_word(9'h024, st);
    check("t5_level", level, 3);
    check("t5_code", LEDCode, 8'h21);
    skip_clear = 1'b1;
    sb_q.delete();
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_lit = 1'b1;
    cmd_code = 8'h25;
    step();
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("t5_code_clr", LEDCode, 8'h00);
    check("t5_lit_clr", Lit, 0);
    check("t5_level_clr", level, 0);
    check("t5_idle", busy, 0);
    check("t5_ready", cmd_ready, 1);
    step();
    check("t5_push_gone", level, 0);
    check("t5_code_stays", LEDCode, 8'h00);

    // 6: simultaneous push and pop at level 2
    push_word(9'h131, st);
    push_word(9'h032, st);
    push_word(9'h133, st);
    step();
    step();
    check("t6_level_pre", level, 2);
    check("t6_code_pre", LEDCode, 8'h31);
    push_word(9'h034, st);
    check("t6_level_post", level, 2);
    check("t6_code_post", LEDCode, 8'h32);
    check("t6_lit_post", Lit, 0);
    wait_idle();
    step();
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
